// File: rtl/router_pkg.sv
// Shared router definitions: flit geometry, flit type codes and the
// wormhole sequence-checker state type. Used by the input buffers and the arbiter.
package router_pkg;

  localparam int FLIT_SIZE  = 32;
  localparam int HEADER_LEN = 2;

  // Flit type codes carried in the top HEADER_LEN bits of every flit.
  localparam logic [HEADER_LEN-1:0] HEAD_FLIT   = 2'b00;
  localparam logic [HEADER_LEN-1:0] BODY_FLIT   = 2'b01;
  localparam logic [HEADER_LEN-1:0] TAIL_FLIT   = 2'b10;
  localparam logic [HEADER_LEN-1:0] SINGLE_FLIT = 2'b11;

  // Field the arbiter compares on (position/length inside the flit).
  localparam int CMP_POS = 0;
  localparam int CMP_LEN = 8;

  // Wormhole ordering state: between packets, or inside a multi-flit packet.
  typedef enum logic {
    SEQ_IDLE   = 1'b0,
    SEQ_IN_PKT = 1'b1
  } seq_state_e;

  // Extract the flit type field.
  function automatic logic [HEADER_LEN-1:0] flit_type(input logic [FLIT_SIZE-1:0] flit);
    return flit[FLIT_SIZE-1 -: HEADER_LEN];
  endfunction

endpackage

// File: rtl/flit_seq_checker.sv
// Wormhole flit-ordering checker. Judges each offered flit type against the
// packet state; a rejected flit sets a sticky error that only rst clears.
// State moves only when a push is offered and the flit is accepted.
module flit_seq_checker
  import router_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [HEADER_LEN-1:0] flit_type,
  input  logic                  push_req,
  output logic                  accept,
  output logic                  err
);

  seq_state_e state_q, state_d;
  logic       err_q, err_d;

  // Acceptance rule and next state from current packet state and flit type.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    if (state_q == SEQ_IDLE) begin
      accept = (flit_type == HEAD_FLIT) || (flit_type == SINGLE_FLIT);
      if (push_req && flit_type == HEAD_FLIT) state_d = SEQ_IN_PKT;
    end else begin
      accept = (flit_type == BODY_FLIT) || (flit_type == TAIL_FLIT);
      if (push_req && flit_type == TAIL_FLIT) state_d = SEQ_IDLE;
    end
    err_d = err_q | (push_req & ~accept);
  end

  // Packet state and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEQ_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: rtl/input_flit_fifo.sv
// Per-port input buffer: DEPTH-entry first-word-fall-through flit FIFO feeding
// one arbiter lane. Optional wormhole ordering check under FIFO_PKT_CHECK_EN.
//
// Handshake: a flit moves upstream->buffer when in_valid && in_avail at a clk
// edge, and buffer->arbiter when out_valid && out_avail at a clk edge. Neither
// valid waits on its avail; out/out_valid come only from registers, so the
// arbiter may derive out_avail from out_valid without a combinational loop.
module input_flit_fifo
  import router_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [FLIT_SIZE-1:0]         in,
  input  logic                         in_valid,
  output logic                         in_avail,
  output logic [FLIT_SIZE-1:0]         out,
  output logic                         out_valid,
  input  logic                         out_avail,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [FLIT_SIZE-1:0] mem_q [DEPTH];
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 accept;
  logic                 push;
  logic                 pop;

`ifdef FIFO_PKT_CHECK_EN
  flit_seq_checker u_seq_checker (
    .clk       (clk),
    .rst       (rst),
    .flit_type (flit_type(in)),
    .push_req  (in_valid && in_avail),
    .accept    (accept),
    .err       (err)
  );
`else
  assign accept = 1'b1;
  assign err    = 1'b0;
`endif

  assign in_avail  = (count_q != CW'(DEPTH)) && !rst;
  assign out_valid = (count_q != '0);
  assign out       = out_valid ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;

  // Rejected flits are consumed from the link but never stored.
  assign push = in_valid && in_avail && accept;
  assign pop  = out_valid && out_avail;

  // Pointer advance with explicit wrap so DEPTH need not be a power of two.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    if (push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    if (push && !pop) count_d = count_q + CW'(1);
    if (pop && !push) count_d = count_q - CW'(1);
  end

  // Pointer and occupancy registers; reset discards everything stored.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Flit storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in;
  end

endmodule
